// File: rtl/gmii_tx_arb.sv
// Round-robin GMII transmit arbiter and framer: preamble/SFD insertion, inter-packet gap,
// and clean TX_ER aborts on link loss, source underrun or overlong frames.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | link free; grant chosen here when operate=1 and a source requests
// S_PRE    | 7 preamble bytes 0x55 being driven
// S_SFD    | start-of-frame delimiter 0xd5 being driven
// S_DATA   | payload bytes forwarded from the granted source
// S_GAP    | inter-packet gap; grant still held, TX_EN low
module gmii_tx_arb #(
  parameter int N       = 2,
  parameter int IPG     = 12,
  parameter int MAX_LEN = 1518
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           operate,
  input  logic [N-1:0]   src_valid,
  input  logic [8*N-1:0] src_data,
  input  logic [N-1:0]   src_last,
  output logic [N-1:0]   src_ready,
  output logic [N-1:0]   grant,
  output logic [7:0]     TXD,
  output logic           TX_EN,
  output logic           TX_ER,
  output logic [15:0]    frame_cnt,
  output logic [15:0]    abort_cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(((IPG > 8) ? IPG : 8) + 1);
  // The IDLE cycle that follows GAP supplies the last idle byte, so GAP itself
  // runs IPG-1 cycles and back-to-back frames see exactly IPG idle cycles.
  localparam int GAP_LOAD = (IPG > 1) ? IPG - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_GAP
  } state_t;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  g_idx;
  logic [PW-1:0]  pick_idx;
  logic           pick_ok;
  logic [TW-1:0]  tmr;
  logic [10:0]    byte_cnt;
  int             cand;

  logic           cur_valid;
  logic           cur_last;
  logic [7:0]     cur_data;
  logic           overlong;
  logic           accept;
  logic           in_frame;
  logic           abort_now;
  logic           done_now;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] v);
    if (int'(v) >= N - 1) return '0;
    return v + 1'b1;
  endfunction

  // Scan downwards so the lowest offset from rr_ptr is the last one written.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N) cand = cand - N;
      if (src_valid[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = PW'(cand);
      end
    end
  end

  always_comb begin
    cur_valid = src_valid[g_idx];
    cur_last  = src_last[g_idx];
    cur_data  = src_data[8*int'(g_idx) +: 8];
    overlong  = (byte_cnt == 11'(MAX_LEN));
    accept    = (state == S_DATA) && operate && !overlong && cur_valid;
    src_ready = accept ? (N'(1) << g_idx) : '0;
    in_frame  = (state == S_PRE) || (state == S_SFD) || (state == S_DATA);
    abort_now = in_frame && (!operate || ((state == S_DATA) && !accept));
    done_now  = accept && cur_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      g_idx     <= '0;
      grant     <= '0;
      tmr       <= '0;
      byte_cnt  <= '0;
      TXD       <= 8'h00;
      TX_EN     <= 1'b0;
      TX_ER     <= 1'b0;
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      TXD   <= 8'h00;
      TX_EN <= 1'b0;
      TX_ER <= 1'b0;
      case (state)
        S_IDLE: begin
          if (operate && pick_ok) begin
            grant <= N'(1) << pick_idx;
            g_idx <= pick_idx;
            tmr   <= TW'(6);
            state <= S_PRE;
          end
        end
        S_PRE: begin
          TXD   <= 8'h55;
          TX_EN <= 1'b1;
          if (tmr == '0) state <= S_SFD;
          else tmr <= tmr - 1'b1;
        end
        S_SFD: begin
          TXD      <= 8'hd5;
          TX_EN    <= 1'b1;
          byte_cnt <= '0;
          state    <= S_DATA;
        end
        S_DATA: begin
          if (accept) begin
            TXD      <= cur_data;
            TX_EN    <= 1'b1;
            byte_cnt <= byte_cnt + 11'd1;
          end
        end
        S_GAP: begin
          if (tmr == '0) begin
            state <= S_IDLE;
            grant <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Link loss, underrun and overlong all collapse into one TX_ER cycle.
      if (abort_now) begin
        TXD       <= 8'h00;
        TX_EN     <= 1'b1;
        TX_ER     <= 1'b1;
        abort_cnt <= abort_cnt + 16'd1;
      end
      if (done_now) frame_cnt <= frame_cnt + 16'd1;
      if (abort_now || done_now) begin
        rr_ptr <= next_ptr(g_idx);
        tmr    <= TW'(GAP_LOAD);
        if (IPG > 1) begin
          state <= S_GAP;
        end else begin
          state <= S_IDLE;
          grant <= '0;
        end
      end
    end
  end

endmodule
